wasm_ctrl_stack: RTL

Parametrised WebAssembly control stack holding call/block/loop/if frames for the flow CPU, the successor to the fixed-size control stack. It adds configurable width/depth, multi-level `br` unwinding in one cycle, automatic function-frame tracking on call-frame push, a peek port for branch targets, and overflow/underflow detection with a sticky fault state. It sits beside the value stack and is driven by the decode/control FSM one operation per cycle.

---
 rtl/wasm_ctrl_stack.sv | 138 +++++++++++++
 1 files changed

// File: rtl/wasm_ctrl_stack.sv
// wasm_ctrl_stack: parametrised WebAssembly control-frame stack with
// one-cycle multi-level br unwinding and function-frame tracking.
module wasm_ctrl_stack #(
    parameter int DATA_W   = 15,
    parameter int DEPTH    = 16,
    parameter int FUNC_MAX = 8,
    parameter int TYPE_LSB = 13,
    parameter int TAG_LSB  = 9,
    parameter int TAG_W    = 4,
    localparam int PW = $clog2(DEPTH) + 1,
    localparam int FW = $clog2(FUNC_MAX) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [PW-1:0]     br_depth,
    input  logic [DATA_W-1:0] push_data,
    input  logic [PW-1:0]     peek,
    input  logic              clr_err,
    output logic              ready,
    output logic [DATA_W-1:0] top_data,
    output logic [PW-1:0]     depth,
    output logic              empty,
    output logic              full,
    output logic              left_one,
    output logic [FW-1:0]     func_count,
    output logic [PW-1:0]     func_base,
    output logic [TAG_W-1:0]  func_tag,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int AW  = $clog2(DEPTH);
    localparam int FAW = (FUNC_MAX > 1) ? $clog2(FUNC_MAX) : 1;
    localparam logic [PW-1:0] FULL_D = PW'(DEPTH);
    localparam logic [FW-1:0] FMAX   = FW'(FUNC_MAX);

    localparam logic [2:0] OP_PUSH = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_RET  = 3'b011;
    localparam logic [2:0] OP_BR   = 3'b100;
    localparam logic [2:0] OP_REPL = 3'b101;

    typedef enum logic {RUN, FAULT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem   [DEPTH];
    logic [PW-1:0]       flist [FUNC_MAX];
    logic [PW-1:0]       dep;
    logic [FW-1:0]       fcnt;

    logic [FAW-1:0]      fidx;
    logic [PW-1:0]       tidx;
    logic [PW-1:0]       last;
    logic [PW-1:0]       br_lim;
    logic                is_call;
    logic                pop_call;
    logic [1:0]          bad;

    always_comb begin
        fidx      = FAW'(fcnt - FW'(1));
        func_base = (fcnt != '0) ? flist[fidx] : '0;
        func_tag  = (fcnt != '0) ? mem[func_base[AW-1:0]][TAG_LSB +: TAG_W] : '0;
        last      = dep - PW'(1);
        tidx      = last - peek;
        top_data  = (peek < dep) ? mem[tidx[AW-1:0]] : '0;
        is_call   = (push_data[TYPE_LSB +: 2] == 2'b01);
        // a pop retires a function only when it removes the tracked call index
        pop_call  = (fcnt != '0) && (func_base == last);
        br_lim    = (fcnt != '0) ? (dep - func_base - PW'(1)) : dep;
        bad       = 2'b00;
        case (op)
            OP_PUSH: if (dep == FULL_D || (is_call && fcnt == FMAX)) bad = 2'b01;
            OP_POP:  if (dep == '0) bad = 2'b10;
            OP_REPL: if (dep == '0) bad = 2'b10;
            OP_RET:  if (fcnt == '0) bad = 2'b10;
            OP_BR:   if (br_depth > br_lim) bad = 2'b11;
            default: bad = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            dep      <= '0;
            fcnt     <= '0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            case (state)
                RUN: if (op_valid && !clr_err) begin
                    if (bad != 2'b00) begin
                        state    <= FAULT;
                        err      <= 1'b1;
                        err_code <= bad;
                    end else begin
                        case (op)
                            OP_PUSH: begin
                                mem[dep[AW-1:0]] <= push_data;
                                dep <= dep + PW'(1);
                                if (is_call) begin
                                    flist[fcnt[FAW-1:0]] <= dep;
                                    fcnt <= fcnt + FW'(1);
                                end
                            end
                            OP_POP: begin
                                dep <= last;
                                if (pop_call) fcnt <= fcnt - FW'(1);
                            end
                            OP_RET: begin
                                dep  <= func_base;
                                fcnt <= fcnt - FW'(1);
                            end
                            OP_BR:   dep <= dep - br_depth;
                            OP_REPL: mem[last[AW-1:0]] <= push_data;
                            default: ;
                        endcase
                    end
                end
                FAULT: if (clr_err) begin
                    state    <= RUN;
                    err      <= 1'b0;
                    err_code <= 2'b00;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign ready    = (state == RUN);
    assign depth    = dep;
    assign func_count = fcnt;
    assign empty    = (dep == '0);
    assign full     = (dep == FULL_D);
    assign left_one = (dep == PW'(1));

endmodule
